// File: rtl/cpu_divider_pkg.sv
// Shared constants and state encoding for the execute-stage divide unit.
package cpu_divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 5;

  localparam logic [5:0] OP_DIVS = 6'b100100;
  localparam logic [5:0] OP_MODS = 6'b100101;
  localparam logic [5:0] OP_DIVU = 6'b100110;
  localparam logic [5:0] OP_MODU = 6'b100111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/cpu_divider.sv
// Iterative restoring radix-2 divider for divs/mods/divu/modu; stalls the
// pipeline via busy and is cancelled by a taken jump.
module cpu_divider
  import cpu_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             hold,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q, r_neg_q, sel_rem_q, valid_q;

  logic             accept;
  logic             is_signed;
  logic [WIDTH-1:0] a_abs, b_abs, quo_fix, rem_fix;
  logic [WIDTH:0]   trial;

  // Operand conditioning and the shift/subtract step
  always_comb begin
    accept    = (state_q == DIV_IDLE) && start && op[2] && !abort;
    is_signed = !op[1];
    a_abs     = (is_signed && a[WIDTH-1]) ? WIDTH'(-a) : a;
    b_abs     = (is_signed && b[WIDTH-1]) ? WIDTH'(-b) : b;
    trial     = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    quo_fix   = q_neg_q ? WIDTH'(-quo_q) : quo_q;
    rem_fix   = r_neg_q ? WIDTH'(-rem_q) : rem_q;
    busy      = !abort && (accept || state_q == DIV_BUSY || state_q == DIV_FIX);
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (accept) state_d = (b == '0) ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_DONE;
      DIV_DONE: if (!hold) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (abort) state_d = DIV_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= DIV_IDLE;
    else          state_q <= state_d;
  end

  // Datapath: rem/quo form one shifting register pair during BUSY
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      sel_rem_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= (state_d == DIV_DONE);
      case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            rem_q     <= '0;
            quo_q     <= a_abs;
            dvs_q     <= b_abs;
            cnt_q     <= '0;
            q_neg_q   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_q   <= is_signed && a[WIDTH-1];
            sel_rem_q <= op[0];
            if (b == '0) result_q <= op[0] ? a : '1;
          end
        end
        DIV_BUSY: begin
          if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CNT_W'(1);
        end
        DIV_FIX: result_q <= sel_rem_q ? rem_fix : quo_fix;
        default: ;
      endcase
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_cpu_divider.sv
// Directed self-checking bench for cpu_divider.
module tb_cpu_divider;
  import cpu_divider_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        abort = 1'b0;
  logic        hold = 1'b0;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;

  int checks = 0;
  int errors = 0;

  logic [2:0] DIVS, MODS, DIVU, MODU;
  logic [5:0] tmp_op;

  cpu_divider dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .hold(hold), .busy(busy), .result(result),
    .result_valid(result_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at cycle 0, measure latency to result_valid, optionally hold DONE.
  task automatic run_div(input string tag, input logic [2:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] exp, input int lat,
                         input int hold_n);
    int n;
    int busy_low;
    @(posedge clock); #1;
    start = 1'b1; op = o; a = aa; b = bb; hold = (hold_n > 0);
    @(negedge clock);
    chk({tag, " busy@0"}, {31'b0, busy}, 32'd1);
    n = 0;
    busy_low = 0;
    while (n < 60) begin
      @(negedge clock);
      n++;
      if (result_valid) break;
      if (!busy) busy_low++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy_gap"}, busy_low, 0);
    chk({tag, " result"}, result, exp);
    chk({tag, " busy@done"}, {31'b0, busy}, 32'd0);
    for (int k = 1; k <= hold_n; k++) begin
      @(posedge clock); #1;
      if (k == hold_n) hold = 1'b0;
      @(negedge clock);
      chk({tag, " hold_valid"}, {31'b0, result_valid}, 32'd1);
      chk({tag, " hold_result"}, result, exp);
    end
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk({tag, " idle_valid"}, {31'b0, result_valid}, 32'd0);
    chk({tag, " idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tmp_op = OP_DIVS; DIVS = tmp_op[2:0];
    tmp_op = OP_MODS; MODS = tmp_op[2:0];
    tmp_op = OP_DIVU; DIVU = tmp_op[2:0];
    tmp_op = OP_MODU; MODU = tmp_op[2:0];

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst valid", {31'b0, result_valid}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Non-divide op ignored
    @(posedge clock); #1;
    start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd3;
    @(negedge clock);
    chk("mul busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    chk("mul busy2", {31'b0, busy}, 32'd0);
    chk("mul valid", {31'b0, result_valid}, 32'd0);
    @(posedge clock); #1;
    start = 1'b0;

    run_div("divu100_7", DIVU, 32'd100, 32'd7, 32'd14, 34, 0);
    run_div("modu100_7", MODU, 32'd100, 32'd7, 32'd2, 34, 0);
    run_div("divs-100_7", DIVS, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34, 0);
    run_div("mods-100_7", MODS, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 34, 0);
    run_div("divs100_-7", DIVS, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34, 0);
    run_div("mods100_-7", MODS, 32'd100, 32'hFFFFFFF9, 32'd2, 34, 0);
    run_div("divs_ovf", DIVS, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 0);
    run_div("mods_ovf", MODS, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34, 0);
    run_div("divu_big", DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 34, 0);
    run_div("modu_big", MODU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 34, 0);
    run_div("divu_by0", DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
    run_div("modu_by0", MODU, 32'd5, 32'd0, 32'd5, 1, 0);
    run_div("divu_hold", DIVU, 32'd100, 32'd7, 32'd14, 34, 3);

    // Abort at cycle 10, restart at cycle 12
    @(posedge clock); #1;
    start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd3;
    for (int c = 1; c <= 9; c++) @(posedge clock);
    #1;
    abort = 1'b1;
    @(negedge clock);
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort valid", {31'b0, result_valid}, 32'd0);
    @(posedge clock); #1;
    abort = 1'b0; start = 1'b0;
    @(negedge clock);
    chk("post_abort busy", {31'b0, busy}, 32'd0);
    chk("post_abort valid", {31'b0, result_valid}, 32'd0);
    run_div("restart", DIVU, 32'd1000, 32'd3, 32'd333, 34, 0);

    // Reset pulsed mid-BUSY
    @(posedge clock); #1;
    start = 1'b1; op = MODU; a = 32'd1000; b = 32'd7;
    repeat (5) @(posedge clock);
    #1;
    reset_n = 1'b0; start = 1'b0;
    #1;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst valid", {31'b0, result_valid}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_div("after_rst", MODU, 32'd1000, 32'd7, 32'd6, 34, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
